// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, payload from a frame buffer,
// zero padding to a minimum length, CRC-32 FCS and inter-frame gap.
module gmii_tx_framer #(
    parameter int ADDR_W     = 11,
    parameter int MIN_LEN    = 60,
    parameter int IFG_CYCLES = 12
) (
    input  logic              TX_CLK,
    input  logic              rst,
    input  logic              tx_start,
    input  logic [ADDR_W-1:0] tx_len,
    output logic [ADDR_W-1:0] tx_addr,
    input  logic [7:0]        tx_mem_out,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              TX_EN,
    output logic [7:0]        TXD,
    output logic              TX_ER
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_SFD  = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_PAD  = 3'd4;
    localparam logic [2:0] S_FCS  = 3'd5;
    localparam logic [2:0] S_IFG  = 3'd6;

    localparam logic [ADDR_W:0]   ZERO     = '0;
    localparam logic [ADDR_W:0]   ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   PRE_LAST = (ADDR_W+1)'(6);
    localparam logic [ADDR_W:0]   FCS_LAST = (ADDR_W+1)'(3);
    localparam logic [ADDR_W:0]   MIN_L    = (ADDR_W+1)'(MIN_LEN);
    localparam logic [ADDR_W:0]   IFG_L    = (ADDR_W+1)'(IFG_CYCLES);
    localparam logic [ADDR_W-1:0] A_ONE    = ADDR_W'(1);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
    logic [ADDR_W:0]   len_q, len_d;
    logic [31:0]       crc_q, crc_d, fcs;
    logic              tx_en_q, tx_en_d;
    logic [7:0]        txd_q, txd_d;
    logic              data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    assign cnt_inc = cnt_q + ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        len_d   = len_q;
        crc_d   = crc_q;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = ZERO;
                crc_d = 32'hFFFF_FFFF;
                if (tx_start) begin
                    state_d = S_PRE;
                    len_d   = {1'b0, tx_len};
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    cnt_d   = ZERO;
                end
            end
            S_SFD: begin
                cnt_d = ZERO;
                if (len_q != ZERO)       state_d = S_DATA;
                else if (MIN_L != ZERO)  state_d = S_PAD;
                else                     state_d = S_FCS;
            end
            S_DATA: begin
                crc_d = crc_byte(crc_q, tx_mem_out);
                // cnt keeps running into PAD so it counts payload+pad bytes
                if (cnt_inc == len_q) begin
                    if (cnt_inc < MIN_L) begin
                        state_d = S_PAD;
                    end else begin
                        state_d = S_FCS;
                        cnt_d   = ZERO;
                    end
                end
            end
            S_PAD: begin
                crc_d = crc_byte(crc_q, 8'h00);
                if (cnt_inc == MIN_L) begin
                    state_d = S_FCS;
                    cnt_d   = ZERO;
                end
            end
            S_FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = ZERO;
                end
            end
            S_IFG: begin
                if (cnt_inc == IFG_L) begin
                    state_d = S_IDLE;
                    cnt_d   = ZERO;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = ZERO;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    assign fcs = ~crc_d;

    always_comb begin
        tx_en_d = (state_d != S_IDLE) && (state_d != S_IFG);
        data_d  = (state_d == S_DATA);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_IFG) && (cnt_d == ZERO);
        addr_d  = '0;
        if (state_d == S_DATA) addr_d = cnt_d[ADDR_W-1:0] + A_ONE;
        txd_d = 8'h00;
        unique case (state_d)
            S_PRE:   txd_d = 8'h55;
            S_SFD:   txd_d = 8'hD5;
            S_FCS:   txd_d = fcs[{cnt_d[1:0], 3'b000} +: 8];
            default: txd_d = 8'h00;
        endcase
    end

    always_ff @(posedge TX_CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            data_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
        end
    end

    // The buffer's synchronous read register supplies payload bytes
    assign TXD     = data_q ? tx_mem_out : txd_q;
    assign TX_EN   = tx_en_q;
    assign TX_ER   = 1'b0;
    assign tx_busy = busy_q;
    assign tx_done = done_q;
    assign tx_addr = addr_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: scoreboarded byte streams on a MIN_LEN=0
// instance and a default instance sharing one frame buffer image.
module tb_gmii_tx_framer;

    logic clk = 1'b0;
    always #4 clk = ~clk;

    logic        rst;
    logic        st0, st1;
    logic [10:0] len0, len1;
    logic [10:0] addr0, addr1;
    logic [7:0]  mo0, mo1;
    logic        busy0, busy1, done0, done1, en0, en1, er0, er1;
    logic [7:0]  txd0, txd1;

    logic [7:0] mem [0:2047];
    always @(posedge clk) begin
        mo0 <= mem[addr0];
        mo1 <= mem[addr1];
    end

    gmii_tx_framer #(.MIN_LEN(0)) dut0 (
        .TX_CLK(clk), .rst(rst), .tx_start(st0), .tx_len(len0),
        .tx_addr(addr0), .tx_mem_out(mo0), .tx_busy(busy0),
        .tx_done(done0), .TX_EN(en0), .TXD(txd0), .TX_ER(er0)
    );

    gmii_tx_framer dut (
        .TX_CLK(clk), .rst(rst), .tx_start(st1), .tx_len(len1),
        .tx_addr(addr1), .tx_mem_out(mo1), .tx_busy(busy1),
        .tx_done(done1), .TX_EN(en1), .TXD(txd1), .TX_ER(er1)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0]  exp_q [$];
    logic        s_en [$];
    logic [7:0]  s_txd [$];
    logic        s_done [$];
    logic        s_busy [$];
    logic [10:0] s_addr [$];

    function automatic logic [31:0] crc_model(input logic [31:0] c,
                                              input logic [7:0]  b);
        logic fb;
        for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ b[j];
            c  = c >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic push_frame(input int n, input int m);
        logic [31:0] c;
        logic [7:0]  b;
        int          t;
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        c = 32'hFFFF_FFFF;
        t = (n > m) ? n : m;
        for (int i = 0; i < t; i++) begin
            b = (i < n) ? mem[i] : 8'h00;
            exp_q.push_back(b);
            c = crc_model(c, b);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) exp_q.push_back(c[8*j +: 8]);
    endtask

    task automatic clr();
        exp_q.delete();
        s_en.delete();
        s_txd.delete();
        s_done.delete();
        s_busy.delete();
        s_addr.delete();
    endtask

    // One clock: drive inputs after the edge, sample outputs mid-cycle
    task automatic cycle(input bit w, input logic st,
                         input logic [10:0] ln, input logic r);
        @(posedge clk);
        #1;
        rst = r;
        if (w) begin st1 = st; len1 = ln; end
        else   begin st0 = st; len0 = ln; end
        @(negedge clk);
        s_en.push_back(w ? en1 : en0);
        s_txd.push_back(w ? txd1 : txd0);
        s_done.push_back(w ? done1 : done0);
        s_busy.push_back(w ? busy1 : busy0);
        s_addr.push_back(w ? addr1 : addr0);
    endtask

    task automatic test_reset();
        clr();
        cycle(0, 1'b0, 11'd0, 1'b1);
        cycle(1, 1'b1, 11'd5, 1'b1);
        cycle(1, 1'b0, 11'd5, 1'b0);
        checks++; if (s_en[1] !== 1'b0) begin failures++; $display("FAIL rst_en got %b want 0", s_en[1]); end
        checks++; if (s_txd[1] !== 8'h00) begin failures++; $display("FAIL rst_txd got %h want 00", s_txd[1]); end
        checks++; if (s_busy[1] !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", s_busy[1]); end
        checks++; if (s_done[1] !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", s_done[1]); end
        checks++; if (s_addr[1] !== 11'd0) begin failures++; $display("FAIL rst_addr got %h want 0", s_addr[1]); end
        checks++; if (s_busy[2] !== 1'b0) begin failures++; $display("FAIL rst_start_ignored busy got %b want 0", s_busy[2]); end
        checks++; if (er1 !== 1'b0 || er0 !== 1'b0) begin failures++; $display("FAIL tx_er got %b%b want 00", er0, er1); end
        checks++; if (en0 !== 1'b0 || busy0 !== 1'b0) begin failures++; $display("FAIL rst_dut0 en %b busy %b want 0 0", en0, busy0); end
    endtask

    task automatic test_min0_crc();
        int n, first, nd;
        logic [7:0] e;
        clr();
        for (int i = 0; i < 9; i++) mem[i] = 8'h31 + 8'(i);
        for (int c = 0; c < 40; c++) begin
            if (c == 0) begin
                repeat (7) exp_q.push_back(8'h55);
                exp_q.push_back(8'hD5);
                for (int i = 0; i < 9; i++) exp_q.push_back(mem[i]);
                exp_q.push_back(8'h26); exp_q.push_back(8'h39);
                exp_q.push_back(8'hF4); exp_q.push_back(8'hCB);
            end
            cycle(0, c == 0, 11'd9, 1'b0);
        end
        n = 0; first = -1; nd = 0;
        for (int k = 0; k < s_en.size(); k++) begin
            if (s_done[k] === 1'b1) nd++;
            if (s_en[k] === 1'b1) begin
                n++;
                if (first < 0) first = k;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL min0_extra cycle %0d got %h want none", k, s_txd[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[k] !== e) begin failures++; $display("FAIL min0_byte cycle %0d got %h want %h", k, s_txd[k], e); end
                end
            end
        end
        checks++; if (n != 21) begin failures++; $display("FAIL min0_en_len got %0d want 21", n); end
        checks++; if (first != 1) begin failures++; $display("FAIL min0_first got %0d want 1", first); end
        checks++; if (s_done[22] !== 1'b1 || nd != 1) begin failures++; $display("FAIL min0_done got %b/%0d want 1/1", s_done[22], nd); end
        checks++; if (s_txd[22] !== 8'h00) begin failures++; $display("FAIL min0_idle_txd got %h want 00", s_txd[22]); end
    endtask

    task automatic test_zero_len();
        int n, nd, na;
        logic [7:0] e;
        clr();
        for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
        for (int c = 0; c < 90; c++) begin
            if (c == 0) push_frame(0, 60);
            cycle(1, c == 0, 11'd0, 1'b0);
        end
        n = 0; nd = 0; na = 0;
        for (int k = 0; k < s_en.size(); k++) begin
            if (s_done[k] === 1'b1) nd++;
            if (s_addr[k] !== 11'd0) na++;
            if (s_en[k] === 1'b1) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL zlen_extra cycle %0d got %h want none", k, s_txd[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[k] !== e) begin failures++; $display("FAIL zlen_byte cycle %0d got %h want %h", k, s_txd[k], e); end
                end
            end
        end
        checks++; if (n != 72 || s_en[1] !== 1'b1) begin failures++; $display("FAIL zlen_en_len got %0d want 72", n); end
        checks++; if (s_done[73] !== 1'b1 || nd != 1) begin failures++; $display("FAIL zlen_done got %b/%0d want 1/1", s_done[73], nd); end
        checks++; if (s_busy[1] !== 1'b1 || s_busy[84] !== 1'b1) begin failures++; $display("FAIL zlen_busy got %b%b want 11", s_busy[1], s_busy[84]); end
        checks++; if (s_busy[85] !== 1'b0) begin failures++; $display("FAIL zlen_idle_busy got %b want 0", s_busy[85]); end
        checks++; if (na != 0) begin failures++; $display("FAIL zlen_addr got %0d nonzero want 0", na); end
    endtask

    task automatic test_len64();
        int n;
        logic [7:0] e;
        clr();
        for (int i = 0; i < 80; i++) mem[i] = 8'(i);
        for (int c = 0; c < 95; c++) begin
            if (c == 0) push_frame(64, 60);
            cycle(1, c == 0, 11'd64, 1'b0);
        end
        n = 0;
        for (int k = 0; k < s_en.size(); k++) begin
            if (s_en[k] === 1'b1) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL len64_extra cycle %0d got %h want none", k, s_txd[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[k] !== e) begin failures++; $display("FAIL len64_byte cycle %0d got %h want %h", k, s_txd[k], e); end
                end
            end
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (s_addr[8+i] !== 11'(i)) begin failures++; $display("FAIL len64_addr cycle %0d got %0d want %0d", 8+i, s_addr[8+i], i); end
        end
        checks++; if (n != 76) begin failures++; $display("FAIL len64_en_len got %0d want 76", n); end
        checks++; if (s_done[77] !== 1'b1) begin failures++; $display("FAIL len64_done got %b want 1", s_done[77]); end
    endtask

    task automatic test_back_to_back();
        int n, nd;
        logic [7:0] e;
        logic st;
        logic [10:0] ln;
        clr();
        for (int i = 0; i < 16; i++) mem[i] = 8'hC0 ^ 8'(i * 7);
        for (int c = 0; c < 175; c++) begin
            st = (c == 0) || (c == 20) || (c == 84) || (c == 85);
            ln = (c == 0) ? 11'd5 : (c == 85) ? 11'd3 : 11'd100;
            if (c == 0)  push_frame(5, 60);
            if (c == 85) push_frame(3, 60);
            cycle(1, st, ln, 1'b0);
        end
        n = 0; nd = 0;
        for (int k = 0; k < s_en.size(); k++) begin
            if (s_done[k] === 1'b1) nd++;
            if (s_en[k] === 1'b1) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL b2b_extra cycle %0d got %h want none", k, s_txd[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[k] !== e) begin failures++; $display("FAIL b2b_byte cycle %0d got %h want %h", k, s_txd[k], e); end
                end
            end
        end
        checks++; if (n != 144) begin failures++; $display("FAIL b2b_en_total got %0d want 144", n); end
        checks++; if (s_en[72] !== 1'b1 || s_en[73] !== 1'b0) begin failures++; $display("FAIL b2b_first_end got %b%b want 10", s_en[72], s_en[73]); end
        checks++; if (s_en[85] !== 1'b0 || s_busy[85] !== 1'b0) begin failures++; $display("FAIL b2b_last_ifg_start en %b busy %b want 0 0", s_en[85], s_busy[85]); end
        checks++; if (s_en[86] !== 1'b1) begin failures++; $display("FAIL b2b_second_start got %b want 1", s_en[86]); end
        checks++; if (nd != 2 || s_done[73] !== 1'b1 || s_done[158] !== 1'b1) begin failures++; $display("FAIL b2b_done got %0d want 2", nd); end
    endtask

    task automatic test_rst_mid();
        int n, nd;
        logic [7:0] e;
        clr();
        for (int i = 0; i < 48; i++) mem[i] = 8'h5A + 8'(i * 3);
        for (int c = 0; c < 130; c++) begin
            if (c == 40) push_frame(9, 60);
            cycle(1, (c == 0) || (c == 30) || (c == 40),
                  (c < 40) ? 11'd40 : 11'd9, c == 30);
        end
        nd = 0;
        for (int k = 0; k < 40; k++) if (s_done[k] === 1'b1) nd++;
        checks++; if (s_en[30] !== 1'b1) begin failures++; $display("FAIL rstmid_pre got %b want 1", s_en[30]); end
        checks++; if (s_en[31] !== 1'b0 || s_txd[31] !== 8'h00) begin failures++; $display("FAIL rstmid_en got %b/%h want 0/00", s_en[31], s_txd[31]); end
        checks++; if (s_busy[31] !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", s_busy[31]); end
        checks++; if (nd != 0) begin failures++; $display("FAIL rstmid_done got %0d want 0", nd); end
        n = 0;
        for (int k = 40; k < s_en.size(); k++) begin
            if (s_en[k] === 1'b1) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL rstmid_extra cycle %0d got %h want none", k, s_txd[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[k] !== e) begin failures++; $display("FAIL rstmid_byte cycle %0d got %h want %h", k, s_txd[k], e); end
                end
            end
        end
        checks++; if (n != 72 || s_en[41] !== 1'b1) begin failures++; $display("FAIL rstmid_new_len got %0d want 72", n); end
        checks++; if (s_done[113] !== 1'b1) begin failures++; $display("FAIL rstmid_new_done got %b want 1", s_done[113]); end
    endtask

    task automatic test_len_change();
        int n;
        logic [7:0] e;
        clr();
        for (int i = 0; i < 120; i++) mem[i] = 8'hF0 - 8'(i);
        for (int c = 0; c < 95; c++) begin
            if (c == 0) push_frame(10, 60);
            cycle(1, c == 0, (c < 2) ? 11'd10 : 11'd100, 1'b0);
        end
        n = 0;
        for (int k = 0; k < s_en.size(); k++) begin
            if (s_en[k] === 1'b1) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL lchg_extra cycle %0d got %h want none", k, s_txd[k]);
                end else begin
                    e = exp_q.pop_front();
                    if (s_txd[k] !== e) begin failures++; $display("FAIL lchg_byte cycle %0d got %h want %h", k, s_txd[k], e); end
                end
            end
        end
        checks++; if (n != 72) begin failures++; $display("FAIL lchg_en_len got %0d want 72", n); end
        checks++; if (s_done[73] !== 1'b1) begin failures++; $display("FAIL lchg_done got %b want 1", s_done[73]); end
    endtask

    initial begin
        rst = 1'b1;
        st0 = 1'b0; st1 = 1'b0;
        len0 = '0; len1 = '0;
        for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
        test_reset();
        test_min0_crc();
        test_zero_len();
        test_len64();
        test_back_to_back();
        test_rst_mid();
        test_len_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
